// File: rtl/timer_seq_ctrl.sv
// rtl/timer_seq_ctrl.sv - countdown timer sequencer for a cascade of external BCD down-counters
module timer_seq_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic [DIGITS-1:0]     cnt_tc,
    output logic                  cnt_load,
    output logic [4*DIGITS-1:0]   cnt_data,
    output logic [DIGITS-1:0]     cnt_en,
    output logic [1:0]            state,
    output logic                  alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [PRE_W-1:0] PRESC_LAST = PRE_W'(TICK_DIV - 1);

    state_t              state_q;
    state_t              state_d;
    logic [4*DIGITS-1:0] entry_q;
    logic [4*DIGITS-1:0] entry_d;
    logic [4*DIGITS-1:0] entry_shift;
    logic [PRE_W-1:0]    presc_q;
    logic [PRE_W-1:0]    presc_d;
    logic                all_zero;
    logic                presc_wrap;
    logic                tick;
    logic                key_ok;

    assign all_zero   = &cnt_tc;
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign key_ok     = key_valid && (key_val <= 4'd9);
    // Clear and the all-zero condition both veto the tick in the same cycle.
    assign tick       = (state_q == ST_RUN) && presc_wrap && !all_zero && !clear;

    generate
        if (DIGITS == 1) begin : g_one_digit
            assign entry_shift = key_val;
        end else begin : g_multi_digit
            assign entry_shift = {entry_q[4*DIGITS-5:0], key_val};
        end
    endgenerate

    // Borrow chain: a digit is enabled when every lower digit is sitting at zero.
    always_comb begin
        logic borrow;
        cnt_en = '0;
        borrow = tick;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_en[i] = borrow;
            borrow    = borrow & cnt_tc[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            entry_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        presc_d = presc_q;
        if (clear) begin
            state_d = ST_IDLE;
            entry_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end else if (key_ok) begin
                        entry_d = entry_shift;
                    end
                end
                ST_RUN: begin
                    if (all_zero) begin
                        state_d = ST_DONE;
                    end else if (pause && !start) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_wrap ? '0 : presc_q + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Entry is kept so a further start replays the same time.
                    if (start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign state    = state_q;
    assign cnt_load = (state_q == ST_IDLE);
    assign cnt_data = entry_q;
    assign alarm    = (state_q == ST_DONE);

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb/tb_timer_seq_ctrl.sv - self-checking bench for timer_seq_ctrl
module tb_timer_seq_ctrl;
    localparam int DIG = 4;
    localparam int TD  = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_val = 4'd0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  cnt_tc;
    logic        cnt_load;
    logic [15:0] cnt_data;
    logic [3:0]  cnt_en;
    logic [1:0]  state;
    logic        alarm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_seq_ctrl #(.DIGITS(DIG), .TICK_DIV(TD), .PRE_W(3)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_val(key_val),
        .start(start), .pause(pause), .clear(clear), .cnt_tc(cnt_tc),
        .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_en(cnt_en),
        .state(state), .alarm(alarm)
    );

    // External mod-10 down-counters driven by the DUT.
    logic [3:0] ctr [DIG] = '{default: 4'd0};
    always @(posedge clk) begin
        for (int i = 0; i < DIG; i++) begin
            if (cnt_load) ctr[i] <= cnt_data[4*i +: 4];
            else if (cnt_en[i]) ctr[i] <= (ctr[i] == 4'd0) ? 4'd9 : ctr[i] - 4'd1;
        end
    end
    always_comb begin
        for (int i = 0; i < DIG; i++) cnt_tc[i] = (ctr[i] == 4'd0);
    end

    function automatic int ctr_num();
        int s = 0;
        int p = 1;
        for (int i = 0; i < DIG; i++) begin
            s += int'(ctr[i]) * p;
            p *= 10;
        end
        return s;
    endfunction

    // Reference model: timer value as a decimal number, prescaler as a phase count.
    int m_state = 0;
    int m_entry = 0;
    int m_count = 0;
    int m_phase = 0;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic model_tick();
        return (m_state == 1) && (m_phase == TD - 1) && (m_count != 0) && !clear;
    endfunction

    // Digits enabled on a tick are exactly the digits that change when the value drops by one.
    function automatic logic [3:0] exp_en();
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  e;
        e = 4'd0;
        if (model_tick()) begin
            a = to_bcd(m_count);
            b = to_bcd(m_count - 1);
            for (int i = 0; i < DIG; i++) e[i] = (a[4*i +: 4] != b[4*i +: 4]);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (m_state == 0) m_count <= m_entry;
        else if (model_tick()) m_count <= m_count - 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_entry <= 0; m_phase <= 0;
        end else if (clear) begin
            m_state <= 0; m_entry <= 0; m_phase <= 0;
        end else begin
            case (m_state)
                0: if (start) begin m_state <= 1; m_phase <= 0; end
                   else if (key_valid && key_val <= 4'd9) m_entry <= (m_entry * 10 + int'(key_val)) % MOD;
                1: if (m_count == 0) m_state <= 3;
                   else if (pause && !start) m_state <= 2;
                   else m_phase <= (m_phase + 1) % TD;
                2: if (start) m_state <= 1;
                default: if (start) m_state <= 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        key_valid = 1'b1; key_val = v;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_tests++; if (cnt_load !== 1'b1) begin n_fail++; $display("FAIL reset_load: got %b expected 1", cnt_load); end
        n_tests++; if (cnt_en !== 4'b0000 || alarm !== 1'b0) begin n_fail++; $display("FAIL reset_en_alarm: got en=%b alarm=%b expected 0000/0", cnt_en, alarm); end
        cyc(); cyc();
        n_tests++; if (cnt_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", cnt_data); end
        n_tests++; if (ctr_num() != 0) begin n_fail++; $display("FAIL reset_counters: got %0d expected 0", ctr_num()); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_keys();
        press(4'd1); press(4'd2); press(4'd0); press(4'd5);
        n_tests++; if (cnt_data !== 16'h1205) begin n_fail++; $display("FAIL keys_entry: got %h expected 1205", cnt_data); end
        n_tests++; if (cnt_load !== 1'b1 || state !== 2'b00) begin n_fail++; $display("FAIL keys_idle: got load=%b state=%b expected 1/00", cnt_load, state); end
        press(4'hA);
        n_tests++; if (cnt_data !== 16'h1205) begin n_fail++; $display("FAIL keys_invalid: got %h expected 1205", cnt_data); end
        repeat (12) begin
            key_valid = 1'($urandom_range(0, 1));
            key_val = 4'($urandom_range(0, 15));
            cyc();
            n_tests++; if (cnt_data !== to_bcd(m_entry)) begin n_fail++; $display("FAIL keys_random: got %h expected %h", cnt_data, to_bcd(m_entry)); end
        end
        clear = 1'b1; key_valid = 1'b1; key_val = 4'd7;
        cyc();
        clear = 1'b0; key_valid = 1'b0;
        n_tests++; if (cnt_data !== 16'h0000) begin n_fail++; $display("FAIL keys_clear: got %h expected 0000", cnt_data); end
    endtask

    task automatic test_countdown();
        int c = 0;
        int ticks = 1;
        int last = -1;
        int done_at = -1;
        press(4'd1); press(4'd0);
        n_tests++; if (cnt_data !== 16'h0010) begin n_fail++; $display("FAIL cd_entry: got %h expected 0010", cnt_data); end
        start = 1'b1; cyc(); start = 1'b0;
        n_tests++; if (state !== 2'b01 || cnt_load !== 1'b0) begin n_fail++; $display("FAIL cd_start: got state=%b load=%b expected 01/0", state, cnt_load); end
        key_valid = 1'b1; key_val = 4'd7;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            key_valid = 1'b0;
            if (k < 3) begin
                n_tests++; if (cnt_en !== 4'b0000) begin n_fail++; $display("FAIL cd_early_en: got %b expected 0000", cnt_en); end
            end else begin
                n_tests++; if (cnt_en !== 4'b0011) begin n_fail++; $display("FAIL cd_first_tick: got %b expected 0011", cnt_en); end
            end
        end
        n_tests++; if (cnt_data !== 16'h0010) begin n_fail++; $display("FAIL cd_key_in_run: got %h expected 0010", cnt_data); end
        cyc();
        n_tests++; if (ctr_num() != 9) begin n_fail++; $display("FAIL cd_after_first: got %0d expected 9", ctr_num()); end
        while (done_at < 0 && c < 200) begin
            cyc(); c++;
            n_tests++; if (cnt_en !== exp_en()) begin n_fail++; $display("FAIL cd_en: got %b expected %b", cnt_en, exp_en()); end
            n_tests++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL cd_state: got %b expected %0d", state, m_state); end
            if (cnt_en !== 4'b0000) begin ticks++; last = c; end
            if (state === 2'b11) done_at = c;
        end
        n_tests++; if (done_at < 0) begin n_fail++; $display("FAIL cd_timeout: got no DONE expected DONE within 200 cycles"); end
        n_tests++; if (ticks != 10) begin n_fail++; $display("FAIL cd_ticks: got %0d expected 10", ticks); end
        n_tests++; if (done_at - last != 2) begin n_fail++; $display("FAIL cd_done_latency: got %0d expected 2", done_at - last); end
        n_tests++; if (alarm !== 1'b1 || ctr_num() != 0) begin n_fail++; $display("FAIL cd_alarm: got alarm=%b count=%0d expected 1/0", alarm, ctr_num()); end
    endtask

    task automatic test_pause();
        int c = 0;
        clear = 1'b1; cyc(); clear = 1'b0;
        press(4'd3);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        n_tests++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_enter: got %b expected 10", state); end
        repeat (20) begin
            pause = 1'($urandom_range(0, 1));
            cyc();
            n_tests++; if (cnt_en !== 4'b0000 || state !== 2'b10) begin n_fail++; $display("FAIL pause_hold: got en=%b state=%b expected 0000/10", cnt_en, state); end
        end
        pause = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        n_tests++; if (state !== 2'b01 || cnt_en !== 4'b0000) begin n_fail++; $display("FAIL pause_resume: got state=%b en=%b expected 01/0000", state, cnt_en); end
        cyc();
        n_tests++; if (cnt_en !== 4'b0001) begin n_fail++; $display("FAIL pause_resume_tick: got %b expected 0001", cnt_en); end
        cyc();
        n_tests++; if (ctr_num() != 2) begin n_fail++; $display("FAIL pause_count: got %0d expected 2", ctr_num()); end
        while (m_state != 3 && c < 400) begin
            pause = ($urandom_range(0, 3) == 0);
            start = !pause && ($urandom_range(0, 3) == 0);
            cyc(); c++;
            n_tests++; if (state !== 2'(m_state) || cnt_en !== exp_en()) begin n_fail++; $display("FAIL pause_random: got state=%b en=%b expected %0d/%b", state, cnt_en, m_state, exp_en()); end
        end
        pause = 1'b0; start = 1'b0;
        n_tests++; if (state !== 2'b11) begin n_fail++; $display("FAIL pause_done: got %b expected 11", state); end
    endtask

    task automatic test_zero();
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        n_tests++; if (state !== 2'b01 || cnt_en !== 4'b0000) begin n_fail++; $display("FAIL zero_run: got state=%b en=%b expected 01/0000", state, cnt_en); end
        cyc();
        n_tests++; if (state !== 2'b11 || alarm !== 1'b1 || cnt_en !== 4'b0000) begin n_fail++; $display("FAIL zero_done: got state=%b alarm=%b en=%b expected 11/1/0000", state, alarm, cnt_en); end
    endtask

    task automatic test_clear_start();
        int c = 0;
        int ticks = 0;
        clear = 1'b1; cyc(); clear = 1'b0;
        press(4'd4); press(4'd2);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        clear = 1'b1; start = 1'b1;
        #1;
        n_tests++; if (cnt_en !== 4'b0000 || exp_en() !== 4'b0000) begin n_fail++; $display("FAIL cs_veto: got %b expected 0000", cnt_en); end
        cyc();
        clear = 1'b0; start = 1'b0;
        n_tests++; if (state !== 2'b00 || cnt_data !== 16'h0000 || cnt_load !== 1'b1) begin n_fail++; $display("FAIL cs_clear: got state=%b data=%h load=%b expected 00/0000/1", state, cnt_data, cnt_load); end
        press(4'd2);
        start = 1'b1; cyc(); start = 1'b0;
        while (state !== 2'b11 && c < 50) begin cyc(); c++; end
        n_tests++; if (state !== 2'b11) begin n_fail++; $display("FAIL cs_reach_done: got %b expected 11", state); end
        start = 1'b1; cyc(); start = 1'b0;
        n_tests++; if (state !== 2'b00 || cnt_data !== 16'h0002) begin n_fail++; $display("FAIL cs_done_restart: got state=%b data=%h expected 00/0002", state, cnt_data); end
        start = 1'b1; cyc(); start = 1'b0;
        c = 0;
        while (state !== 2'b11 && c < 50) begin
            cyc(); c++;
            if (cnt_en !== 4'b0000) ticks++;
        end
        n_tests++; if (ticks != 2 || state !== 2'b11) begin n_fail++; $display("FAIL cs_repeat: got ticks=%0d state=%b expected 2/11", ticks, state); end
    endtask

    task automatic test_async_reset();
        int c = 0;
        clear = 1'b1; cyc(); clear = 1'b0;
        press(4'd1); press(4'd5);
        start = 1'b1; cyc(); start = 1'b0;
        while (exp_en() == 4'b0000 && c < 20) begin cyc(); c++; end
        n_tests++; if (cnt_en === 4'b0000) begin n_fail++; $display("FAIL ar_pre: got %b expected nonzero", cnt_en); end
        reset = 1'b1;
        #1;
        n_tests++; if (state !== 2'b00 || alarm !== 1'b0) begin n_fail++; $display("FAIL ar_state: got state=%b alarm=%b expected 00/0", state, alarm); end
        n_tests++; if (cnt_en !== 4'b0000 || cnt_load !== 1'b1 || cnt_data !== 16'h0000) begin n_fail++; $display("FAIL ar_outputs: got en=%b load=%b data=%h expected 0000/1/0000", cnt_en, cnt_load, cnt_data); end
        cyc();
        n_tests++; if (ctr_num() != 0) begin n_fail++; $display("FAIL ar_reload: got %0d expected 0", ctr_num()); end
        reset = 1'b0;
        cyc();
        n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL ar_after: got %b expected 00", state); end
    endtask

    task automatic test_random();
        clear = 1'b1; cyc(); clear = 1'b0;
        repeat (3000) begin
            key_valid = ($urandom_range(0, 9) < 4);
            key_val = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 19) == 0);
            pause = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 199) == 0);
            cyc();
            n_tests++; if (state !== 2'(m_state) || alarm !== (m_state == 3) || cnt_load !== (m_state == 0)) begin n_fail++; $display("FAIL rand_state: got state=%b alarm=%b load=%b expected %0d", state, alarm, cnt_load, m_state); end
            n_tests++; if (cnt_en !== exp_en()) begin n_fail++; $display("FAIL rand_en: got %b expected %b", cnt_en, exp_en()); end
            n_tests++; if (cnt_data !== to_bcd(m_entry)) begin n_fail++; $display("FAIL rand_data: got %h expected %h", cnt_data, to_bcd(m_entry)); end
        end
        key_valid = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_keys();
        test_countdown();
        test_pause();
        test_zero();
        test_clear_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
